// File: rtl/icache_fetcher.sv
// Instruction fetch stage with a small direct-mapped cache. Each line holds one
// instruction. Misses go out on the shared program-memory read channel.
module icache_fetcher #(
  parameter int PROGRAM_MEM_ADDR_BITS = 8,
  parameter int PROGRAM_MEM_DATA_BITS = 16,
  parameter int CACHE_LINES           = 8,
  parameter int COUNTER_BITS          = 16
) (
  input  logic                             clk,
  input  logic                             reset,
  input  logic [2:0]                       core_state,
  input  logic [PROGRAM_MEM_ADDR_BITS-1:0] current_pc,
  input  logic                             cache_flush,
  output logic                             mem_read_valid,
  output logic [PROGRAM_MEM_ADDR_BITS-1:0] mem_read_address,
  input  logic                             mem_read_ready,
  input  logic [PROGRAM_MEM_DATA_BITS-1:0] mem_read_data,
  output logic [2:0]                       fetcher_state,
  output logic [PROGRAM_MEM_DATA_BITS-1:0] instruction,
  output logic [COUNTER_BITS-1:0]          hit_count,
  output logic [COUNTER_BITS-1:0]          miss_count
);
  localparam int IDX_BITS = $clog2(CACHE_LINES);
  localparam int TAG_BITS = PROGRAM_MEM_ADDR_BITS - IDX_BITS;

  localparam logic [2:0] CORE_FETCH  = 3'b001;
  localparam logic [2:0] CORE_DECODE = 3'b010;

  typedef enum logic [2:0] {
    S_IDLE     = 3'b000,
    S_FETCHING = 3'b001,
    S_FETCHED  = 3'b010,
    S_LOOKUP   = 3'b011
  } state_t;

  state_t                             r_state;
  logic [PROGRAM_MEM_ADDR_BITS-1:0]   r_pc;
  logic                               r_req;
  logic [PROGRAM_MEM_ADDR_BITS-1:0]   r_addr;
  logic [PROGRAM_MEM_DATA_BITS-1:0]   r_instr;
  logic [COUNTER_BITS-1:0]            r_hits;
  logic [COUNTER_BITS-1:0]            r_misses;
  logic [CACHE_LINES-1:0]             r_valid;
  logic [TAG_BITS-1:0]                r_tag  [CACHE_LINES];
  logic [PROGRAM_MEM_DATA_BITS-1:0]   r_data [CACHE_LINES];

  logic [IDX_BITS-1:0] w_idx;
  logic [TAG_BITS-1:0] w_tag;
  logic                w_hit;
  logic                w_fill;

  // Index/tag always come from the latched PC; current_pc is only sampled in IDLE.
  assign w_idx  = r_pc[IDX_BITS-1:0];
  assign w_tag  = r_pc[PROGRAM_MEM_ADDR_BITS-1:IDX_BITS];
  assign w_hit  = r_valid[w_idx] && (r_tag[w_idx] == w_tag);
  assign w_fill = (r_state == S_FETCHING) && mem_read_ready;

  assign fetcher_state    = r_state;
  assign mem_read_valid   = r_req;
  assign mem_read_address = r_addr;
  assign instruction      = r_instr;
  assign hit_count        = r_hits;
  assign miss_count       = r_misses;

  // Fetch FSM, request channel, statistics and line valid bits.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state  <= S_IDLE;
      r_pc     <= '0;
      r_req    <= 1'b0;
      r_addr   <= '0;
      r_instr  <= '0;
      r_hits   <= '0;
      r_misses <= '0;
      r_valid  <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (core_state == CORE_FETCH) begin
            r_pc    <= current_pc;
            r_state <= S_LOOKUP;
          end
        end
        S_LOOKUP: begin
          if (w_hit) begin
            r_instr <= r_data[w_idx];
            if (r_hits != '1) r_hits <= r_hits + COUNTER_BITS'(1);
            r_state <= S_FETCHED;
          end else begin
            r_req   <= 1'b1;
            r_addr  <= r_pc;
            if (r_misses != '1) r_misses <= r_misses + COUNTER_BITS'(1);
            r_state <= S_FETCHING;
          end
        end
        S_FETCHING: begin
          if (mem_read_ready) begin
            r_req          <= 1'b0;
            r_instr        <= mem_read_data;
            r_valid[w_idx] <= 1'b1;
            r_state        <= S_FETCHED;
          end
        end
        S_FETCHED: begin
          if (core_state == CORE_DECODE) r_state <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
      // Flush wins over a same-cycle fill: the line stays invalid.
      if (cache_flush) r_valid <= '0;
    end
  end

  // Tag/data arrays are written on every fill; valid bits alone gate their use.
  always_ff @(posedge clk) begin
    if (!reset && w_fill) begin
      r_tag[w_idx]  <= w_tag;
      r_data[w_idx] <= mem_read_data;
    end
  end
endmodule

// File: tb/tb_icache_fetcher.sv
// Directed bench for icache_fetcher with a reference cache model and an
// expected-instruction scoreboard.
module tb_icache_fetcher;
  logic        clk = 1'b0;
  logic        reset;
  logic [2:0]  core_state;
  logic [7:0]  current_pc;
  logic        cache_flush;
  logic        mem_read_valid;
  logic [7:0]  mem_read_address;
  logic        mem_read_ready;
  logic [15:0] mem_read_data;
  logic [2:0]  fetcher_state;
  logic [15:0] instruction;
  logic [3:0]  hit_count;
  logic [3:0]  miss_count;

  icache_fetcher #(
    .PROGRAM_MEM_ADDR_BITS(8), .PROGRAM_MEM_DATA_BITS(16),
    .CACHE_LINES(8), .COUNTER_BITS(4)
  ) dut (
    .clk(clk), .reset(reset), .core_state(core_state), .current_pc(current_pc),
    .cache_flush(cache_flush), .mem_read_valid(mem_read_valid),
    .mem_read_address(mem_read_address), .mem_read_ready(mem_read_ready),
    .mem_read_data(mem_read_data), .fetcher_state(fetcher_state),
    .instruction(instruction), .hit_count(hit_count), .miss_count(miss_count)
  );

  always #5 clk = ~clk;

  int vectors = 0;
  int miscompares = 0;

  // reference model
  logic [7:0]  m_valid;
  logic [4:0]  m_tag  [8];
  logic [15:0] m_data [8];
  int          m_hit, m_miss;
  logic [15:0] sb [$];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic chk_counts();
    chk("hit_count", 32'(hit_count), 32'(m_hit));
    chk("miss_count", 32'(miss_count), 32'(m_miss));
  endtask

  // One complete fetch: FETCH -> LOOKUP -> (FETCHING ->) FETCHED -> DECODE -> IDLE.
  task automatic fetch(input logic [7:0] pc, input logic [15:0] md, input int lat,
                       input bit fl_fill, input bit fl_look);
    logic [2:0]  idx;
    logic [4:0]  tg;
    logic [15:0] exp;
    bit          hit;
    idx = pc[2:0];
    tg  = pc[7:3];
    hit = m_valid[idx] && (m_tag[idx] == tg);
    sb.push_back(hit ? m_data[idx] : md);
    core_state = 3'b001; current_pc = pc;
    tick();
    chk("lookup_state", 32'(fetcher_state), 32'd3);
    // pc and core_state changes after IDLE must be ignored
    core_state = 3'b100; current_pc = ~pc;
    if (fl_look) cache_flush = 1'b1;
    tick();
    cache_flush = 1'b0;
    if (fl_look) m_valid = '0;
    if (hit) begin
      if (m_hit < 15) m_hit++;
      chk("hit_state", 32'(fetcher_state), 32'd2);
      chk("hit_noreq", 32'(mem_read_valid), 32'd0);
    end else begin
      if (m_miss < 15) m_miss++;
      chk("miss_state", 32'(fetcher_state), 32'd1);
      chk("req_valid", 32'(mem_read_valid), 32'd1);
      chk("req_addr", 32'(mem_read_address), 32'(pc));
      for (int i = 0; i < lat; i++) begin
        tick();
        chk("req_hold", 32'(mem_read_valid), 32'd1);
        chk("addr_hold", 32'(mem_read_address), 32'(pc));
      end
      mem_read_ready = 1'b1; mem_read_data = md; cache_flush = fl_fill;
      tick();
      mem_read_ready = 1'b0; cache_flush = 1'b0; mem_read_data = 16'($urandom);
      m_data[idx] = md;
      if (fl_fill) m_valid = '0;
      else begin m_valid[idx] = 1'b1; m_tag[idx] = tg; end
      chk("fill_state", 32'(fetcher_state), 32'd2);
      chk("req_drop", 32'(mem_read_valid), 32'd0);
    end
    exp = sb.pop_front();
    chk("instruction", 32'(instruction), 32'(exp));
    chk_counts();
    core_state = 3'b010;
    tick();
    core_state = 3'b000;
    chk("decode_idle", 32'(fetcher_state), 32'd0);
    chk("instr_held", 32'(instruction), 32'(exp));
  endtask

  task automatic flush_pulse();
    cache_flush = 1'b1;
    tick();
    cache_flush = 1'b0;
    m_valid = '0;
  endtask

  initial begin
    reset = 1'b1; core_state = 3'b000; current_pc = 8'h00; cache_flush = 1'b0;
    mem_read_ready = 1'b0; mem_read_data = 16'h0000;
    m_valid = '0; m_hit = 0; m_miss = 0;
    tick(); tick();
    reset = 1'b0;
    chk("rst_state", 32'(fetcher_state), 32'd0);
    chk("rst_valid", 32'(mem_read_valid), 32'd0);
    chk("rst_addr", 32'(mem_read_address), 32'd0);
    chk("rst_instr", 32'(instruction), 32'd0);
    chk_counts();

    // cold miss, warm hit
    fetch(8'h05, 16'h3123, 3, 1'b0, 1'b0);
    fetch(8'h05, 16'h0000, 0, 1'b0, 1'b0);
    // conflict eviction on line 5
    fetch(8'h0D, 16'h9207, 2, 1'b0, 1'b0);
    fetch(8'h0D, 16'h0000, 0, 1'b0, 1'b0);
    fetch(8'h05, 16'h3123, 1, 1'b0, 1'b0);
    // stray ready while idle must not disturb anything
    mem_read_ready = 1'b1; mem_read_data = 16'hDEAD;
    tick();
    mem_read_ready = 1'b0;
    chk("stray_idle_state", 32'(fetcher_state), 32'd0);
    chk("stray_idle_instr", 32'(instruction), 32'h3123);
    fetch(8'h05, 16'h0000, 0, 1'b0, 1'b0);
    // flush, then refetch misses
    flush_pulse();
    fetch(8'h05, 16'h3123, 1, 1'b0, 1'b0);
    // flush coincident with fill: instruction updates, line stays invalid
    fetch(8'h21, 16'hBEEF, 2, 1'b1, 1'b0);
    fetch(8'h21, 16'hBEEF, 0, 1'b0, 1'b0);
    // flush during lookup: lookup still hits on pre-flush state
    fetch(8'h21, 16'h0000, 0, 1'b0, 1'b1);
    fetch(8'h21, 16'hBEEF, 1, 1'b0, 1'b0);

    // reset with a request outstanding
    core_state = 3'b001; current_pc = 8'h13;
    tick();
    core_state = 3'b100;
    tick();
    chk("pre_rst_req", 32'(mem_read_valid), 32'd1);
    reset = 1'b1;
    tick();
    reset = 1'b0; core_state = 3'b000;
    m_valid = '0; m_hit = 0; m_miss = 0;
    chk("midrst_req", 32'(mem_read_valid), 32'd0);
    chk("midrst_state", 32'(fetcher_state), 32'd0);
    chk("midrst_instr", 32'(instruction), 32'd0);
    chk_counts();
    mem_read_ready = 1'b1; mem_read_data = 16'h5555;
    tick();
    mem_read_ready = 1'b0;
    chk("stray_rst_state", 32'(fetcher_state), 32'd0);
    chk("stray_rst_instr", 32'(instruction), 32'd0);
    fetch(8'h13, 16'h1313, 2, 1'b0, 1'b0);

    // hit counter saturation
    fetch(8'h07, 16'h0777, 1, 1'b0, 1'b0);
    for (int i = 0; i < 17; i++) fetch(8'h07, 16'h0000, 0, 1'b0, 1'b0);
    chk("hit_sat", 32'(hit_count), 32'hF);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
